// File: rtl/region_pantalla_pipe.sv
// Raster position -> framebuffer address -> 24-bit RGB; latency MemLatency+2, 1 pixel/cycle, no backpressure.
// Optional TEST_PATTERN_EN adds a testPattern input that overrides memory data with 8 vertical colour bars.
module region_pantalla_pipe #(
   parameter int          ColorBits   = 3,
   parameter int          ColorMode   = 0,
   parameter int          screenX     = 320,
   parameter int          screenY     = 240,
   parameter int          ScaleShift  = 1,
   parameter int          MemLatency  = 1,
   parameter int          AddrWidth   = 17,
   parameter logic [23:0] BorderColor = 24'hFFFFFF
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [9:0]           posicionX,
   input  logic [9:0]           posicionY,
   input  logic                 displayEnable,
`ifdef TEST_PATTERN_EN
   input  logic                 testPattern,
`endif
   input  logic [ColorBits-1:0] readValueMemory,
   output logic [AddrWidth-1:0] readAddress,
   output logic [7:0]           red,
   output logic [7:0]           green,
   output logic [7:0]           blue,
   output logic                 pixelValid
);

   localparam logic [10:0] SX_LIM = 11'(screenX);
   localparam logic [10:0] SY_LIM = 11'(screenY);

   logic [9:0]           sx, sy;
   logic                 in_region;
   logic [AddrWidth-1:0] addr_next;

   assign sx        = posicionX >> ScaleShift;
   assign sy        = posicionY >> ScaleShift;
   assign in_region = ({1'b0, sx} < SX_LIM) && ({1'b0, sy} < SY_LIM);
   // Outside the framebuffer the read is parked at address 0 so it never goes out of range.
   assign addr_next = in_region ? (AddrWidth'(sy) * AddrWidth'(screenX) + AddrWidth'(sx))
                                : '0;

   // Index 0 is the stage-A register; index MemLatency lines up with readValueMemory.
   logic [MemLatency:0] in_pipe, en_pipe;

   logic [7:0] r_exp, g_exp, b_exp;

   generate
      if (ColorMode == 0) begin : g_rgb111
         assign r_exp = {8{readValueMemory[0]}};
         assign g_exp = {8{readValueMemory[1]}};
         assign b_exp = {8{readValueMemory[2]}};
      end else if (ColorMode == 1) begin : g_rgb332
         assign r_exp = {readValueMemory[7:5], readValueMemory[7:5], readValueMemory[7:6]};
         assign g_exp = {readValueMemory[4:2], readValueMemory[4:2], readValueMemory[4:3]};
         assign b_exp = {4{readValueMemory[1:0]}};
      end else begin : g_rgb444
         assign r_exp = {2{readValueMemory[11:8]}};
         assign g_exp = {2{readValueMemory[7:4]}};
         assign b_exp = {2{readValueMemory[3:0]}};
      end
   endgenerate

`ifdef TEST_PATTERN_EN
   logic [13:0]         sx_times8;
   logic [2:0]          bar_next;
   logic [2:0]          bar_pipe [MemLatency:0];
   logic [MemLatency:0] tp_pipe;

   assign sx_times8 = {1'b0, sx, 3'b000};
   assign bar_next  = 3'(sx_times8 / 14'(screenX));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tp_pipe <= '0;
         for (int i = 0; i <= MemLatency; i++) bar_pipe[i] <= '0;
      end else begin
         tp_pipe     <= {tp_pipe[MemLatency-1:0], testPattern};
         bar_pipe[0] <= bar_next;
         for (int i = 1; i <= MemLatency; i++) bar_pipe[i] <= bar_pipe[i-1];
      end
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         readAddress <= '0;
         in_pipe     <= '0;
         en_pipe     <= '0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         pixelValid  <= 1'b0;
      end else begin
         readAddress <= addr_next;
         in_pipe     <= {in_pipe[MemLatency-1:0], in_region};
         en_pipe     <= {en_pipe[MemLatency-1:0], displayEnable};
         if (!en_pipe[MemLatency]) begin
            {red, green, blue} <= 24'h000000;
            pixelValid         <= 1'b0;
         end else if (!in_pipe[MemLatency]) begin
            {red, green, blue} <= BorderColor;
            pixelValid         <= 1'b1;
`ifdef TEST_PATTERN_EN
         end else if (tp_pipe[MemLatency]) begin
            red        <= {8{bar_pipe[MemLatency][0]}};
            green      <= {8{bar_pipe[MemLatency][1]}};
            blue       <= {8{bar_pipe[MemLatency][2]}};
            pixelValid <= 1'b1;
`endif
         end else begin
            red        <= r_exp;
            green      <= g_exp;
            blue       <= b_exp;
            pixelValid <= 1'b1;
         end
      end
   end

endmodule

// File: doc/region_pantalla_pipe.md
Name: region_pantalla_pipe

Overview:
Parametrised successor to the fixed 320x240 3-bit region-to-RGB mapper. Converts VGA raster position into a framebuffer read address, compensates fixed memory read latency, and expands the returned pixel into 24-bit RGB. Supports integer pixel upscaling, selectable colour formats, a programmable border colour and blanking. Sits between the VGA timing generator, the framebuffer RAM and the DAC/output pins.

Parameters:
ColorBits, 3, width of readValueMemory (must be 3, 8 or 12 to match ColorMode)
ColorMode, 0, 0=RGB111 (bit0 R, bit1 G, bit2 B), 1=RGB332 ([7:5]R [4:2]G [1:0]B), 2=RGB444 ([11:8]R [7:4]G [3:0]B)
screenX, 320, framebuffer width in pixels
screenY, 240, framebuffer height in pixels
ScaleShift, 1, upscale factor 2^ScaleShift (0..2); raster coordinates are right-shifted by this amount
MemLatency, 1, cycles from readAddress to valid readValueMemory (1..4)
AddrWidth, 17, readAddress width; must hold screenX*screenY-1
BorderColor, 24'hFFFFFF, RGB driven for enabled pixels outside the framebuffer region

Ports:
clock  input  1  pixel clock
reset_n  input  1  asynchronous active-low reset
posicionX  input  10  raster X from timing generator
posicionY  input  10  raster Y from timing generator
displayEnable  input  1  high during visible raster area
readValueMemory  input  ColorBits  framebuffer data, valid MemLatency cycles after readAddress
readAddress  output  AddrWidth  framebuffer read address (registered)
red  output  8  red channel
green  output  8  green channel
blue  output  8  blue channel
pixelValid  output  1  high when red/green/blue correspond to an enabled raster position

Behaviour:
- Reset (reset_n low, asynchronous): readAddress=0, red/green/blue=0, pixelValid=0, all delay-line stages cleared. Release is synchronous to the next clock edge; no output glitches to non-zero before the pipeline refills.
- Stage A (cycle 0->1): sx=posicionX>>ScaleShift, sy=posicionY>>ScaleShift; inRegion = (sx<screenX)&&(sy<screenY). readAddress <= inRegion ? sy*screenX+sx : 0 (out-of-region reads are forced to address 0, never out of range). inRegion and displayEnable are registered alongside.
- Delay line: inRegion/displayEnable (and the test-pattern bar index when enabled) are shifted MemLatency further stages to align with readValueMemory.
- Stage C (output register): displayEnable_d=0 -> RGB=000000, pixelValid=0; else inRegion_d=0 -> RGB=BorderColor, pixelValid=1; else RGB=expand(readValueMemory), pixelValid=1.
- Total latency position->RGB = MemLatency+2 cycles (3 at defaults); throughput 1 pixel/cycle, no stalls.
- Expansion by bit replication to 8 bits: 1-bit -> 00/FF; 3-bit abc -> abcabcab; 2-bit ab -> abababab; 4-bit abcd -> abcdabcd.
- Multiply sy*screenX uses constant screenX; result truncated to AddrWidth (legal parameter sets never overflow).
- Position jumps (e.g. hsync wrap X 799->0) need no special handling; each cycle is independent.

Optional Feature:
TEST_PATTERN_EN: adds input port testPattern (1 bit). When high, in-region enabled pixels show 8 vertical colour bars instead of memory data: bar = sx*8/screenX (0..7), colour = RGB111 of bar index (bit0 R, bit1 G, bit2 B) expanded to 00/FF; border, blanking and latency unchanged; readAddress still generated. Without the macro, the port and logic do not exist.

Test Plan:
- reset_n low mid-frame while outputs show FF0000 -> red/green/blue=0, pixelValid=0 immediately (no clock); after release first valid RGB appears exactly 3 cycles after first enabled position.
- Defaults, pos (0,0), en=1, memory returns 3'b101 -> readAddress=0 after 1 cycle; RGB=FF00FF, pixelValid=1 at cycle 3.
- pos (639,479) -> readAddress=76799; pos (640,0) en=1 -> readAddress=0, RGB=FFFFFF at cycle 3.
- Scaling: pos (2,2) and (3,3) -> both readAddress=321; ScaleShift=0, pos (2,2) -> 642.
- ColorMode=1, ColorBits=8, data 8'b11101001 -> red=FF, green=49, blue=55; ColorMode=2, data 12'hA5C -> AA/55/CC.
- displayEnable=0 at in-region pos -> RGB=000000, pixelValid=0; MemLatency=4 -> latency 6 cycles, data correctly aligned.
